reseed_controller: RTL and testbench

RESEED_CONTROLLER -- requirements
Module: reseed_controller

---
 rtl/reseed_controller.sv | 161 ++++++++++++++++
 tb/tb_reseed_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reseed_controller.sv
// Reseed controller: asks a TRNG for a seed, health-checks it, offers it to the
// DRBG and tracks generated blocks against the reseed interval.
module reseed_controller #(
    parameter int SEED_WIDTH      = 256,
    parameter int RESEED_INTERVAL = 1024,
    parameter int TIMEOUT         = 64,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reseed_req,
    input  logic                  gen_tick,
    output logic                  start_seed_collection,
    input  logic [SEED_WIDTH-1:0] seed_in,
    input  logic                  seed_ready_in,
    output logic [SEED_WIDTH-1:0] seed_out,
    output logic                  seed_valid,
    input  logic                  seed_ack,
    output logic                  reseed_due,
    output logic [15:0]           block_count,
    output logic [3:0]            retry_count,
    output logic                  error,
    input  logic                  clear_err,
    output logic [2:0]            dbg_state_o
);

    // Encoding follows the natural flow order; dbg_state_o exposes it as-is.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQUEST = 3'd1,
        S_WAIT    = 3'd2,
        S_CHECK   = 3'd3,
        S_HOLD    = 3'd4,
        S_FAIL    = 3'd5
    } state_e;

    localparam logic [15:0] INTERVAL     = 16'(RESEED_INTERVAL);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_e                  state_q, state_d;
    logic                    seeded_q, seeded_d;
    logic [7:0]              timer_q, timer_d;
    logic [SEED_WIDTH-1:0]   cand_q, cand_d;
    logic [SEED_WIDTH-1:0]   seed_out_q, seed_out_d;
    logic                    seed_valid_q, seed_valid_d;
    logic [15:0]             block_q, block_d;
    logic [3:0]              retry_q, retry_d;
    logic                    error_q, error_d;
    logic                    fail_attempt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            seeded_q     <= 1'b0;
            timer_q      <= '0;
            cand_q       <= '0;
            seed_out_q   <= '0;
            seed_valid_q <= 1'b0;
            block_q      <= '0;
            retry_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            seeded_q     <= seeded_d;
            timer_q      <= timer_d;
            cand_q       <= cand_d;
            seed_out_q   <= seed_out_d;
            seed_valid_q <= seed_valid_d;
            block_q      <= block_d;
            retry_q      <= retry_d;
            error_q      <= error_d;
        end
    end

    // Seed handshake: seed_out is offered while seed_valid=1 and is transferred
    // on the rising edge where seed_valid=1 and seed_ack=1; the offer is held
    // stable until then. A tick on that edge is dropped, the count restarts at 0.
    always_comb begin
        state_d      = state_q;
        seeded_d     = seeded_q;
        timer_d      = timer_q;
        cand_d       = cand_q;
        seed_out_d   = seed_out_q;
        seed_valid_d = seed_valid_q;
        retry_d      = retry_q;
        error_d      = error_q;
        fail_attempt = 1'b0;
        block_d      = block_q;
        if (gen_tick && (block_q < INTERVAL)) begin
            block_d = block_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (reseed_req || reseed_due || !seeded_q) begin
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (seed_ready_in) begin
                    cand_d  = seed_in;
                    state_d = S_CHECK;
                end else if (timer_q == TIMEOUT_LAST) begin
                    fail_attempt = 1'b1;
                end
            end
            S_CHECK: begin
                if ((cand_q == '0) || (&cand_q)) begin
                    fail_attempt = 1'b1;
                end else begin
                    seed_out_d   = cand_q;
                    seed_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (seed_ack) begin
                    seed_valid_d = 1'b0;
                    block_d      = '0;
                    retry_d      = '0;
                    seeded_d     = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_FAIL: begin
                if (clear_err) begin
                    error_d = 1'b0;
                    retry_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail_attempt) begin
            retry_d = retry_q + 4'd1;
            if (retry_d == RETRY_LIMIT) begin
                state_d = S_FAIL;
                error_d = 1'b1;
            end else begin
                state_d = S_REQUEST;
            end
        end
    end

    assign start_seed_collection = (state_q == S_REQUEST);
    assign seed_out              = seed_out_q;
    assign seed_valid            = seed_valid_q;
    assign reseed_due            = (block_q >= INTERVAL);
    assign block_count           = block_q;
    assign retry_count           = retry_q;
    assign error                 = error_q;
    assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_reseed_controller.sv
// Bench for reseed_controller: cycle model plus seed scoreboard on one instance,
// and a second instance with a short timeout for the retry/error path.
module tb_reseed_controller;

    localparam int W     = 64;
    localparam int INTV  = 4;
    localparam int TMO   = 16;
    localparam int TMO_B = 8;
    localparam int MAXR  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          reseed_req = 1'b0, gen_tick = 1'b0, seed_ready_in = 1'b0;
    logic          seed_ack = 1'b0, clear_err = 1'b0;
    logic [W-1:0]  seed_in = '0;
    logic          start_o, valid_o, due_o, err_o;
    logic [W-1:0]  seed_out_o;
    logic [15:0]   bc_o;
    logic [3:0]    rc_o;
    logic [2:0]    dbg_o;

    logic          t_clear_err = 1'b0;
    logic          t_start, t_valid, t_due, t_err;
    logic [W-1:0]  t_seed_out;
    logic [15:0]   t_bc;
    logic [3:0]    t_rc;
    logic [2:0]    t_dbg;

    int  cmp_count = 0;
    int  fail_count = 0;
    bit  rel_done = 0;
    bit  tmo_done = 0;
    logic [W-1:0] exp_q[$];

    reseed_controller #(.SEED_WIDTH(W), .RESEED_INTERVAL(INTV), .TIMEOUT(TMO), .MAX_RETRIES(MAXR)) u_dut (
        .clk(clk), .rst_n(rst_n), .reseed_req(reseed_req), .gen_tick(gen_tick),
        .start_seed_collection(start_o), .seed_in(seed_in), .seed_ready_in(seed_ready_in),
        .seed_out(seed_out_o), .seed_valid(valid_o), .seed_ack(seed_ack),
        .reseed_due(due_o), .block_count(bc_o), .retry_count(rc_o), .error(err_o),
        .clear_err(clear_err), .dbg_state_o(dbg_o)
    );

    reseed_controller #(.SEED_WIDTH(W), .RESEED_INTERVAL(INTV), .TIMEOUT(TMO_B), .MAX_RETRIES(MAXR)) u_tmo (
        .clk(clk), .rst_n(rst_n), .reseed_req(1'b0), .gen_tick(1'b0),
        .start_seed_collection(t_start), .seed_in({W{1'b0}}), .seed_ready_in(1'b0),
        .seed_out(t_seed_out), .seed_valid(t_valid), .seed_ack(1'b0),
        .reseed_due(t_due), .block_count(t_bc), .retry_count(t_rc), .error(t_err),
        .clear_err(t_clear_err), .dbg_state_o(t_dbg)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic give_seed(input logic [W-1:0] v);
        seed_in = v;
        seed_ready_in = 1'b1;
        cycle();
        seed_ready_in = 1'b0;
        seed_in = '0;
    endtask

    task automatic ack();
        seed_ack = 1'b1;
        cycle();
        seed_ack = 1'b0;
    endtask

    // Reference model: phases of a reseed attempt, stepped with the inputs that
    // the next rising edge will sample; outputs compared on every falling edge.
    initial begin : compare_proc
        localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_CHK = 3, M_HOLD = 4, M_FAIL = 5;
        int           m_phase = M_IDLE;
        int           m_age = 0, m_blk = 0, m_retry = 0, nblk;
        bit           m_valid = 0, m_seeded = 0, m_err = 0, failed;
        logic [W-1:0] m_cand = '0, m_seed = '0, exp_seed;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = M_IDLE; m_age = 0; m_blk = 0; m_retry = 0;
                m_valid = 0; m_seeded = 0; m_err = 0; m_cand = '0; m_seed = '0;
            end
            chk("start", start_o, (m_phase == M_REQ));
            chk("seed_valid", valid_o, m_valid);
            chk("seed_out", seed_out_o, m_seed);
            chk("reseed_due", due_o, (m_blk >= INTV));
            chk("block_count", bc_o, m_blk);
            chk("retry_count", rc_o, m_retry);
            chk("error", err_o, m_err);
            if (rst_n) begin
                if (valid_o && seed_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_seed", 1, 0);
                    end else begin
                        exp_seed = exp_q.pop_front();
                        chk("sb_seed", seed_out_o, exp_seed);
                    end
                end
                nblk = m_blk;
                if (gen_tick && m_blk < INTV) nblk = m_blk + 1;
                failed = 0;
                case (m_phase)
                    M_IDLE: if (reseed_req || m_blk >= INTV || !m_seeded) m_phase = M_REQ;
                    M_REQ: begin m_phase = M_WAIT; m_age = 0; end
                    M_WAIT: begin
                        m_age++;
                        if (seed_ready_in) begin m_cand = seed_in; m_phase = M_CHK; end
                        else if (m_age == TMO) failed = 1;
                    end
                    M_CHK: begin
                        if (m_cand == '0 || m_cand == {W{1'b1}}) failed = 1;
                        else begin m_seed = m_cand; m_valid = 1; m_phase = M_HOLD; end
                    end
                    M_HOLD: if (seed_ack) begin
                        m_valid = 0; nblk = 0; m_retry = 0; m_seeded = 1; m_phase = M_IDLE;
                    end
                    default: if (clear_err) begin m_err = 0; m_retry = 0; m_phase = M_IDLE; end
                endcase
                if (failed) begin
                    m_retry++;
                    if (m_retry == MAXR) begin m_phase = M_FAIL; m_err = 1; end
                    else m_phase = M_REQ;
                end
                m_blk = nblk;
            end
        end
    end

    // Short-timeout instance: never fed a seed, must give up after three pulses.
    initial begin : tmo_proc
        int pulses[$];
        int err_idx = -1;
        wait (rel_done);
        for (int idx = 1; idx <= 60; idx++) begin
            cycle();
            if (t_start) pulses.push_back(idx);
            if (t_err) begin err_idx = idx; break; end
        end
        chk("tmo_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            chk("tmo_first_pulse", pulses[0], 1);
            chk("tmo_gap1", pulses[1] - pulses[0], 9);
            chk("tmo_gap2", pulses[2] - pulses[1], 9);
        end
        chk("tmo_error_cycle", err_idx, 28);
        chk("tmo_retry", t_rc, 3);
        chk("tmo_state_fail", t_dbg, 3'd5);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("tmo_fail_no_start", t_start, 0);
            chk("tmo_fail_error_held", t_err, 1);
        end
        t_clear_err = 1'b1;
        cycle();
        t_clear_err = 1'b0;
        chk("tmo_clr_state_idle", t_dbg, 3'd0);
        chk("tmo_clr_error", t_err, 0);
        chk("tmo_clr_retry", t_rc, 0);
        cycle();
        chk("tmo_restart_pulse", t_start, 1);
        tmo_done = 1;
    end

    initial begin : main_proc
        #1 rst_n = 1'b0;
        cycle(); cycle();
        chk("rst_start", start_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_seed_out", seed_out_o, 0);
        chk("rst_bc", bc_o, 0);
        chk("rst_state", dbg_o, 3'd0);

        // Cold start, with a stray ack while waiting and a long stall in HOLD.
        rst_n = 1'b1;
        rel_done = 1;
        cycle();
        chk("cold_start_pulse", start_o, 1);
        cycle();
        chk("cold_start_one_cycle", start_o, 0);
        ack();
        repeat (6) cycle();
        exp_q.push_back(64'h0123456789ABCDEF);
        give_seed(64'h0123456789ABCDEF);
        chk("cold_check_no_valid", valid_o, 0);
        cycle();
        chk("cold_valid", valid_o, 1);
        chk("cold_seed_out", seed_out_o, 64'h0123456789ABCDEF);
        seed_ready_in = 1'b1; seed_in = '1; reseed_req = 1'b1; clear_err = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("stall_valid", valid_o, 1);
            chk("stall_seed_out", seed_out_o, 64'h0123456789ABCDEF);
        end
        seed_ready_in = 1'b0; seed_in = '0; reseed_req = 1'b0; clear_err = 1'b0;
        ack();
        chk("cold_ack_idle", dbg_o, 3'd0);
        chk("cold_ack_bc", bc_o, 0);
        cycle();
        chk("cold_idle_no_start", start_o, 0);

        // Health failure on an all-zero seed, then a good one.
        reseed_req = 1'b1;
        cycle();
        chk("health_req_latency", start_o, 1);
        repeat (3) cycle();
        give_seed('0);
        cycle();
        chk("health_retry1", rc_o, 1);
        chk("health_second_pulse", start_o, 1);
        cycle();
        exp_q.push_back({8{8'hA5}});
        give_seed({8{8'hA5}});
        cycle();
        reseed_req = 1'b0;
        chk("health_seed_out", seed_out_o, {8{8'hA5}});
        ack();
        chk("health_retry_cleared", rc_o, 0);

        // Block interval: saturation, due-triggered request, tick dropped on ack.
        gen_tick = 1'b1;
        repeat (4) cycle();
        chk("intv_bc4", bc_o, 4);
        chk("intv_due", due_o, 1);
        cycle();
        gen_tick = 1'b0;
        chk("intv_bc_sat", bc_o, 4);
        chk("intv_start", start_o, 1);
        cycle();
        exp_q.push_back(64'h0F1E2D3C4B5A6978);
        give_seed(64'h0F1E2D3C4B5A6978);
        cycle();
        gen_tick = 1'b1;
        ack();
        gen_tick = 1'b0;
        chk("intv_ack_tick_dropped", bc_o, 0);
        chk("intv_due_cleared", due_o, 0);

        for (int i = 0; i < 200 && !tmo_done; i++) cycle();
        chk("tmo_proc_done", tmo_done, 1);

        // Reset in WAIT clears everything at once; restart on release.
        gen_tick = 1'b1;
        repeat (2) cycle();
        gen_tick = 1'b0;
        reseed_req = 1'b1;
        cycle();
        reseed_req = 1'b0;
        cycle(); cycle();
        chk("pre_rst_in_wait", dbg_o, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_seed_out", seed_out_o, 0);
        chk("async_rst_bc", bc_o, 0);
        chk("async_rst_state", dbg_o, 3'd0);
        chk("async_rst_valid", valid_o, 0);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        chk("restart_pulse", start_o, 1);
        cycle();
        exp_q.push_back(64'h1122334455667788);
        give_seed(64'h1122334455667788);
        cycle();
        ack();
        cycle();
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
